transaccion_sesion: RTL and testbench
=====================================

// Module: transaccion_sesion
// PURPOSE
//  Parametrised successor of the single-shot ATM transaction unit. Holds the account balance for one card
//  session and runs any number of deposit / withdrawal / balance-query transactions against it.
//  Enforces a per-session withdrawal limit and rejects invalid or overflowing requests.
//  Sits between the card/PIN front end (tarjeta_recibida) and the cash dispenser (entregar_dinero).
// PARAMETERS
//  MONTO_W        32     width of the requested amount
//  BALANCE_W      64     width of the account balance (BALANCE_W >= MONTO_W)
//  LIMITE_SESION  1000   maximum cumulative withdrawal per session, same units as monto
// PORTS
//  clk                  in   1          system clock, rising edge
//  reset                in   1          asynchronous, active-low reset
//  tarjeta_recibida     in   1          card present; level, high for the whole session
//  balance_inicial      in   BALANCE_W  account balance; sampled when the session opens
//  trans_valida         in   1          request strobe; accepted only when listo=1
//  tipo_trans           in   2          00 deposito, 01 retiro, 10 consulta, 11 invalid
//  monto                in   MONTO_W    amount; sampled with trans_valida
//  listo                out  1          ready to accept a request
//  balance_actualizado  out  BALANCE_W  balance after the last successful transaction
//  balance_stb          out  1          1-cycle pulse: balance_actualizado is valid
//  entregar_dinero      out  1          1-cycle pulse: dispense monto
//  fondos_insuficientes out  1          1-cycle pulse: withdrawal > balance
//  limite_excedido      out  1          1-cycle pulse: withdrawal would exceed LIMITE_SESION
//  trans_error          out  1          1-cycle pulse: tipo 11, monto=0 on deposito/retiro, or deposit overflow
// BEHAVIOUR
//  - Reset (reset=0, any time): state=IDLE; all outputs 0; saldo, acumulado and balance_actualizado cleared.
//  - FSM states: IDLE, ESPERA, CALCULA, RESULTADO.
//    - IDLE -> ESPERA when tarjeta_recibida=1. On that edge: saldo<=balance_inicial, acumulado<=0.
//    - ESPERA: listo=1. A cycle with trans_valida=1 latches tipo_trans and monto, then -> CALCULA.
//    - CALCULA: listo=0. Computes the result into next-state registers; no outputs change. -> RESULTADO.
//    - RESULTADO: listo=0. Exactly one result pulse is high for exactly this cycle. -> ESPERA.
//    - Latency: request accepted at edge N; pulse visible from edge N+2 to N+3; listo=1 again after edge N+3.
//  - Decision priority (first match wins):
//    1. trans_error.
//    2. retiro with monto > saldo -> fondos_insuficientes.
//    3. retiro with acumulado+monto > LIMITE_SESION -> limite_excedido.
//    4. Otherwise success.
//  - Success outcomes:
//    - deposito: saldo+=monto.
//    - retiro: saldo-=monto, acumulado+=monto, entregar_dinero=1.
//    - consulta: saldo unchanged; monto ignored.
//    - In all success cases: balance_actualizado<=new saldo and balance_stb=1 in RESULTADO.
//    - entregar_dinero and balance_stb coincide on a successful retiro.
//  - On any rejection, saldo, acumulado and balance_actualizado are unchanged and balance_stb stays 0.
//  - Arithmetic:
//    - monto is zero-extended to BALANCE_W.
//    - Deposit overflow is detected on the BALANCE_W+1 bit sum and rejected via trans_error; no wrap-around.
//    - acumulado is MONTO_W+1 bits wide so the limit compare cannot wrap.
//  - trans_valida while listo=0 is ignored; it is not queued.
//  - tarjeta_recibida=0 in any non-IDLE state:
//    - -> IDLE next edge; any in-flight request is aborted with no pulse;
//    - balance_actualizado keeps its last value; listo=0.
//  - Card removed and reinserted: new session; balance_inicial reloaded; acumulado cleared.
//  - tarjeta_recibida and trans_valida on the same edge in IDLE: the session opens; the request is ignored.
// TESTING
//  - Open, balance_inicial=500, retiro 200 -> edge N+2: entregar_dinero=1, balance_stb=1, balance_actualizado=300.
//  - Balance 300, retiro 400 -> fondos_insuficientes=1 only; balance unchanged; a following consulta returns 300.
//  - LIMITE_SESION=1000, balance 5000: retiro 600 ok, then retiro 500 -> limite_excedido=1; then retiro 400 ok, balance 4000.
//  - Balance 2^64-10, deposito 20 -> trans_error=1, no stb; tipo 11 -> trans_error; deposito monto=0 -> trans_error.
//  - Card removed in CALCULA -> no pulse, IDLE; reinsert with balance_inicial=77, consulta -> 77 and acumulado cleared.
//  - reset=0 asserted mid-RESULTADO -> all outputs 0 asynchronously; trans_valida during listo=0 -> ignored, no second result.

Source files
------------

// File: rtl/transaccion_sesion.sv
// transaccion_sesion: multi-transaction ATM session unit (deposit/withdraw/query).
// Holds one card session's balance, enforces a per-session withdrawal limit.
//
// Ports:
//   clk                  rising-edge clock
//   reset                asynchronous active-low reset
//   tarjeta_recibida     card present (level, high for whole session)
//   balance_inicial      account balance, loaded when the session opens
//   trans_valida         request strobe, taken only while listo=1
//   tipo_trans           00 deposito, 01 retiro, 10 consulta, 11 invalid
//   monto                request amount, sampled with trans_valida
//   listo                ready for a request
//   balance_actualizado  balance after last successful transaction
//   balance_stb          1-cycle pulse, balance_actualizado valid
//   entregar_dinero      1-cycle pulse, dispense monto
//   fondos_insuficientes 1-cycle pulse, withdrawal above balance
//   limite_excedido      1-cycle pulse, session limit would be exceeded
//   trans_error          1-cycle pulse, bad type, zero amount or overflow
module transaccion_sesion #(
    parameter int MONTO_W       = 32,
    parameter int BALANCE_W     = 64,
    parameter int LIMITE_SESION = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tarjeta_recibida,
    input  logic [BALANCE_W-1:0] balance_inicial,
    input  logic                 trans_valida,
    input  logic [1:0]           tipo_trans,
    input  logic [MONTO_W-1:0]   monto,
    output logic                 listo,
    output logic [BALANCE_W-1:0] balance_actualizado,
    output logic                 balance_stb,
    output logic                 entregar_dinero,
    output logic                 fondos_insuficientes,
    output logic                 limite_excedido,
    output logic                 trans_error
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ESPERA    = 2'd1;
    localparam logic [1:0] CALCULA   = 2'd2;
    localparam logic [1:0] RESULTADO = 2'd3;

    localparam logic [1:0] T_DEP = 2'b00;
    localparam logic [1:0] T_RET = 2'b01;
    localparam logic [1:0] T_CON = 2'b10;
    localparam logic [1:0] T_INV = 2'b11;

    localparam logic [MONTO_W:0] LIMITE = (MONTO_W+1)'(LIMITE_SESION);

    logic [1:0]           estado;
    logic                 paso;
    logic [1:0]           tipo_q;
    logic [MONTO_W-1:0]   monto_q;
    logic [BALANCE_W-1:0] saldo;
    logic [MONTO_W:0]     acumulado;

    // Decision registered in the first CALCULA cycle, applied on entry
    // to RESULTADO so the pulse lands two edges after acceptance.
    logic                 res_err;
    logic                 res_fondos;
    logic                 res_limite;
    logic                 res_ok;
    logic                 res_ret;
    logic [BALANCE_W-1:0] saldo_nuevo;
    logic [MONTO_W:0]     acum_nuevo;

    logic [BALANCE_W-1:0] monto_ext;
    logic [BALANCE_W:0]   suma;
    logic [MONTO_W:0]     acum_suma;
    logic                 es_dep;
    logic                 es_ret;
    logic                 es_inv;
    logic                 monto_cero;
    logic                 d_err;
    logic                 d_fondos;
    logic                 d_limite;
    logic                 d_ok;
    logic [BALANCE_W-1:0] d_saldo;
    logic [MONTO_W:0]     d_acum;

    assign listo = (estado == ESPERA);

    assign monto_ext  = BALANCE_W'(monto_q);
    // One extra bit so a deposit carry is visible instead of wrapping.
    assign suma       = {1'b0, saldo} + {1'b0, monto_ext};
    assign acum_suma  = acumulado + {1'b0, monto_q};
    assign es_dep     = (tipo_q == T_DEP);
    assign es_ret     = (tipo_q == T_RET);
    assign es_inv     = (tipo_q == T_INV);
    assign monto_cero = (monto_q == '0);

    always_comb begin
        d_err    = es_inv
                 | ((es_dep | es_ret) & monto_cero)
                 | (es_dep & suma[BALANCE_W]);
        d_fondos = ~d_err & es_ret & (monto_ext > saldo);
        d_limite = ~d_err & ~d_fondos & es_ret & (acum_suma > LIMITE);
        d_ok     = ~d_err & ~d_fondos & ~d_limite;
    end

    always_comb begin
        d_saldo = saldo;
        d_acum  = acumulado;
        unique case (tipo_q)
            T_DEP: d_saldo = suma[BALANCE_W-1:0];
            T_RET: begin
                d_saldo = saldo - monto_ext;
                d_acum  = acum_suma;
            end
            T_CON: d_saldo = saldo;
            T_INV: d_saldo = saldo;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado               <= IDLE;
            paso                 <= 1'b0;
            tipo_q               <= '0;
            monto_q              <= '0;
            saldo                <= '0;
            acumulado            <= '0;
            res_err              <= 1'b0;
            res_fondos           <= 1'b0;
            res_limite           <= 1'b0;
            res_ok               <= 1'b0;
            res_ret              <= 1'b0;
            saldo_nuevo          <= '0;
            acum_nuevo           <= '0;
            balance_actualizado  <= '0;
            balance_stb          <= 1'b0;
            entregar_dinero      <= 1'b0;
            fondos_insuficientes <= 1'b0;
            limite_excedido      <= 1'b0;
            trans_error          <= 1'b0;
        end else begin
            balance_stb          <= 1'b0;
            entregar_dinero      <= 1'b0;
            fondos_insuficientes <= 1'b0;
            limite_excedido      <= 1'b0;
            trans_error          <= 1'b0;
            unique case (estado)
                IDLE: begin
                    if (tarjeta_recibida) begin
                        estado    <= ESPERA;
                        saldo     <= balance_inicial;
                        acumulado <= '0;
                    end
                end
                ESPERA: begin
                    if (!tarjeta_recibida) begin
                        estado <= IDLE;
                    end else if (trans_valida) begin
                        tipo_q  <= tipo_trans;
                        monto_q <= monto;
                        paso    <= 1'b0;
                        estado  <= CALCULA;
                    end
                end
                CALCULA: begin
                    if (!tarjeta_recibida) begin
                        estado <= IDLE;
                    end else if (!paso) begin
                        paso        <= 1'b1;
                        res_err     <= d_err;
                        res_fondos  <= d_fondos;
                        res_limite  <= d_limite;
                        res_ok      <= d_ok;
                        res_ret     <= d_ok & es_ret;
                        saldo_nuevo <= d_saldo;
                        acum_nuevo  <= d_acum;
                    end else begin
                        estado               <= RESULTADO;
                        trans_error          <= res_err;
                        fondos_insuficientes <= res_fondos;
                        limite_excedido      <= res_limite;
                        entregar_dinero      <= res_ret;
                        balance_stb          <= res_ok;
                        if (res_ok) begin
                            saldo               <= saldo_nuevo;
                            acumulado           <= acum_nuevo;
                            balance_actualizado <= saldo_nuevo;
                        end
                    end
                end
                RESULTADO: begin
                    estado <= tarjeta_recibida ? ESPERA : IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_transaccion_sesion.sv
// tb_transaccion_sesion: directed table-driven bench for transaccion_sesion.
// Pulse vector order: {balance_stb, entregar_dinero, fondos, limite, error}.
module tb_transaccion_sesion;

    logic        clk;
    logic        reset;
    logic        tarjeta_recibida;
    logic [63:0] balance_inicial;
    logic        trans_valida;
    logic [1:0]  tipo_trans;
    logic [31:0] monto;
    logic        listo;
    logic [63:0] balance_actualizado;
    logic        balance_stb;
    logic        entregar_dinero;
    logic        fondos_insuficientes;
    logic        limite_excedido;
    logic        trans_error;
    logic [4:0]  pulsos;

    int n_chk;
    int n_fail;

    transaccion_sesion #(
        .MONTO_W(32),
        .BALANCE_W(64),
        .LIMITE_SESION(1000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tarjeta_recibida(tarjeta_recibida),
        .balance_inicial(balance_inicial),
        .trans_valida(trans_valida),
        .tipo_trans(tipo_trans),
        .monto(monto),
        .listo(listo),
        .balance_actualizado(balance_actualizado),
        .balance_stb(balance_stb),
        .entregar_dinero(entregar_dinero),
        .fondos_insuficientes(fondos_insuficientes),
        .limite_excedido(limite_excedido),
        .trans_error(trans_error)
    );

    assign pulsos = {balance_stb, entregar_dinero, fondos_insuficientes,
                     limite_excedido, trans_error};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        abrir;
        logic [63:0] bal_ini;
        logic [1:0]  tipo;
        logic [31:0] monto;
        logic [4:0]  exp_pulsos;
        logic [63:0] exp_bal;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_listo();
        int k;
        k = 0;
        while (listo !== 1'b1 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("wait_listo", {63'd0, listo}, 64'd1);
    endtask

    task automatic issue(input logic [1:0] t, input logic [31:0] m);
        trans_valida = 1'b1;
        tipo_trans   = t;
        monto        = m;
        @(posedge clk);
        #1;
        trans_valida = 1'b0;
    endtask

    task automatic abrir(input logic [63:0] bal);
        tarjeta_recibida = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        balance_inicial  = bal;
        tarjeta_recibida = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_trans(input int id, input logic [1:0] t,
                             input logic [31:0] m, input logic [4:0] ep,
                             input logic [63:0] eb);
        wait_listo();
        issue(t, m);
        chk($sformatf("v%0d_listo_busy", id), {63'd0, listo}, 64'd0);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_calc_quiet", id), {59'd0, pulsos}, 64'd0);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_pulsos", id), {59'd0, pulsos}, {59'd0, ep});
        chk($sformatf("v%0d_balance", id), balance_actualizado, eb);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_pulse_end", id), {59'd0, pulsos}, 64'd0);
        chk($sformatf("v%0d_listo_back", id), {63'd0, listo}, 64'd1);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        vecs[0]  = '{1'b1, 64'd500,  2'b01, 32'd200,  5'b11000, 64'd300};
        vecs[1]  = '{1'b0, 64'd0,    2'b01, 32'd400,  5'b00100, 64'd300};
        vecs[2]  = '{1'b0, 64'd0,    2'b10, 32'd123,  5'b10000, 64'd300};
        vecs[3]  = '{1'b1, 64'd5000, 2'b01, 32'd600,  5'b11000, 64'd4400};
        vecs[4]  = '{1'b0, 64'd0,    2'b01, 32'd500,  5'b00010, 64'd4400};
        vecs[5]  = '{1'b0, 64'd0,    2'b01, 32'd400,  5'b11000, 64'd4000};
        vecs[6]  = '{1'b0, 64'd0,    2'b01, 32'd1,    5'b00010, 64'd4000};
        vecs[7]  = '{1'b0, 64'd0,    2'b00, 32'd1000, 5'b10000, 64'd5000};
        vecs[8]  = '{1'b0, 64'd0,    2'b11, 32'd5,    5'b00001, 64'd5000};
        vecs[9]  = '{1'b0, 64'd0,    2'b00, 32'd0,    5'b00001, 64'd5000};
        vecs[10] = '{1'b0, 64'd0,    2'b01, 32'd0,    5'b00001, 64'd5000};
        vecs[11] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF6, 2'b00, 32'd20,
                     5'b00001, 64'd5000};
        vecs[12] = '{1'b0, 64'd0,    2'b00, 32'd10,   5'b00001, 64'd5000};
        vecs[13] = '{1'b0, 64'd0,    2'b00, 32'd9,    5'b10000,
                     64'hFFFF_FFFF_FFFF_FFFF};
        vecs[14] = '{1'b0, 64'd0,    2'b10, 32'd0,    5'b10000,
                     64'hFFFF_FFFF_FFFF_FFFF};
        vecs[15] = '{1'b1, 64'd100,  2'b01, 32'd100,  5'b11000, 64'd0};
        vecs[16] = '{1'b0, 64'd0,    2'b01, 32'd1,    5'b00100, 64'd0};
        vecs[17] = '{1'b1, 64'd5000, 2'b01, 32'd1000, 5'b11000, 64'd4000};
        vecs[18] = '{1'b0, 64'd0,    2'b01, 32'd4500, 5'b00100, 64'd4000};

        reset            = 1'b0;
        tarjeta_recibida = 1'b0;
        balance_inicial  = '0;
        trans_valida     = 1'b0;
        tipo_trans       = 2'b00;
        monto            = '0;
        @(posedge clk);
        #1;
        chk("rst_listo", {63'd0, listo}, 64'd0);
        chk("rst_pulsos", {59'd0, pulsos}, 64'd0);
        chk("rst_balance", balance_actualizado, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Session open and request on the same edge: request dropped.
        tarjeta_recibida = 1'b1;
        balance_inicial  = 64'd500;
        trans_valida     = 1'b1;
        tipo_trans       = 2'b01;
        monto            = 32'd50;
        @(posedge clk);
        #1;
        trans_valida = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("open_req_quiet%0d", i), {59'd0, pulsos}, 64'd0);
            @(posedge clk);
            #1;
        end
        chk("open_req_listo", {63'd0, listo}, 64'd1);
        chk("open_req_bal", balance_actualizado, 64'd0);

        for (int i = 0; i < 19; i++) begin
            if (vecs[i].abrir) abrir(vecs[i].bal_ini);
            run_trans(i, vecs[i].tipo, vecs[i].monto,
                      vecs[i].exp_pulsos, vecs[i].exp_bal);
        end

        // Card pulled while the request sits in CALCULA.
        wait_listo();
        issue(2'b00, 32'd5);
        @(posedge clk);
        #1;
        tarjeta_recibida = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_pulsos", {59'd0, pulsos}, 64'd0);
        chk("abort_listo", {63'd0, listo}, 64'd0);
        chk("abort_bal", balance_actualizado, 64'd4000);
        @(posedge clk);
        #1;
        chk("abort_pulsos2", {59'd0, pulsos}, 64'd0);
        balance_inicial  = 64'd77;
        tarjeta_recibida = 1'b1;
        @(posedge clk);
        #1;
        run_trans(100, 2'b10, 32'd0, 5'b10000, 64'd77);

        // Requests while busy are not queued.
        wait_listo();
        issue(2'b01, 32'd10);
        trans_valida = 1'b1;
        tipo_trans   = 2'b00;
        monto        = 32'd5;
        @(posedge clk);
        #1;
        chk("busy_calc_quiet", {59'd0, pulsos}, 64'd0);
        @(posedge clk);
        #1;
        chk("busy_pulsos", {59'd0, pulsos}, 64'b11000);
        chk("busy_bal", balance_actualizado, 64'd67);
        @(posedge clk);
        #1;
        trans_valida = 1'b0;
        chk("busy_listo", {63'd0, listo}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("busy_quiet%0d", i), {59'd0, pulsos}, 64'd0);
        end
        chk("busy_bal_hold", balance_actualizado, 64'd67);

        // Asynchronous reset in the middle of RESULTADO.
        wait_listo();
        issue(2'b10, 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("arst_pre_stb", {59'd0, pulsos}, 64'b10000);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_pulsos", {59'd0, pulsos}, 64'd0);
        chk("arst_listo", {63'd0, listo}, 64'd0);
        chk("arst_bal", balance_actualizado, 64'd0);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
